// File: rtl/flash_xip_pkg.sv
// flash_xip_pkg: shared constants, FSM encodings and shifter config type for the XIP controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package flash_xip_pkg;

    // Quad I/O Read opcode and the mode byte that keeps the flash out of continuous-read mode
    localparam logic [7:0] CMD_QIOR  = 8'hEB;
    localparam logic [7:0] MODE_BITS = 8'h00;

    // Flash clocks per transaction phase
    localparam logic [5:0] CLK_CMD   = 6'd8;
    localparam logic [5:0] CLK_ADDR  = 6'd6;
    localparam logic [5:0] CLK_MODE  = 6'd2;
    localparam logic [5:0] CLK_DUMMY = 6'd4;
    localparam logic [5:0] CLK_DATA  = 6'd32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CS    = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_ADDR  = 3'd3;
    localparam logic [2:0] ST_MODE  = 3'd4;
    localparam logic [2:0] ST_DUMMY = 3'd5;
    localparam logic [2:0] ST_DATA  = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // One shifter phase: nibble-wide or bit-serial, driving or listening, clock count, MSB-aligned payload
    typedef struct packed {
        logic        quad;
        logic        oe;
        logic [5:0]  nclk;
        logic [31:0] tx;
    } shift_cfg_t;

    // Bit offset in the line of received nibble n: bytes land little-endian, high nibble arrives first
    function automatic logic [6:0] nib_bit_pos(input logic [4:0] n);
        return {n[4:1], ~n[0], 2'b00};
    endfunction

endpackage

// File: rtl/flash_xip_ctrl_qspi_shifter.sv
// qspi_shifter: HCLK/2 flash clock generator with bit/nibble shift-out and nibble shift-in for one phase.
// Latency: 2 HCLK per flash clock; done asserts on the edge that ends the last flash clock.
// Backpressure: none; a new start may be issued on the done edge so phases run back to back.
// Ports: start_vld/cfg load a phase; done, rx_vld/rx_dat report progress; fdi/fdo/fdoe/fsclk are pins.
module qspi_shifter
    import flash_xip_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       start_vld,
    input  shift_cfg_t cfg,
    output logic       done,
    output logic       rx_vld,
    output logic [3:0] rx_dat,
    input  logic [3:0] fdi,
    output logic [3:0] fdo,
    output logic       fdoe,
    output logic       fsclk
);

    logic        busy_q;
    logic        sclk_q;
    logic [5:0]  cnt_q;
    logic [31:0] tx_q;
    logic        quad_q;
    logic        oe_q;

    // The edge that drops fsclk is both the sample point and the shift point for the next output
    assign rx_vld = busy_q & sclk_q;
    assign rx_dat = fdi;
    assign done   = rx_vld & (cnt_q == 6'd1);

    assign fsclk = sclk_q;
    assign fdoe  = oe_q;
    assign fdo   = !oe_q ? 4'h0 : (quad_q ? tx_q[31:28] : {3'b000, tx_q[31]});

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            cnt_q  <= '0;
            tx_q   <= '0;
            quad_q <= 1'b0;
            oe_q   <= 1'b0;
        end else if (start_vld) begin
            busy_q <= 1'b1;
            sclk_q <= 1'b0;
            cnt_q  <= cfg.nclk;
            tx_q   <= cfg.tx;
            quad_q <= cfg.quad;
            oe_q   <= cfg.oe;
        end else if (busy_q) begin
            if (!sclk_q) begin
                sclk_q <= 1'b1;
            end else begin
                sclk_q <= 1'b0;
                cnt_q  <= cnt_q - 6'd1;
                tx_q   <= quad_q ? {tx_q[27:0], 4'h0} : {tx_q[30:0], 1'b0};
                if (cnt_q == 6'd1) begin
                    busy_q <= 1'b0;
                    oe_q   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/flash_xip_ctrl.sv
// flash_xip_ctrl: AHB-Lite read-only XIP bridge to quad-SPI flash (0xEB reads) with one 16-byte line buffer.
// Latency: line hit returns data with zero wait states; a miss inserts 106 wait states (CS + 52 flash clocks + DONE).
// Backpressure: HREADYOUT held low for the whole line fill; writes complete at once with OKAY and are dropped.
// Ports: HCLK/HRESETn clock and async active-low reset; H* AHB-Lite slave; fdi/fdo/fdoe/fsclk/fcen QSPI pins.
module flash_xip_ctrl
    import flash_xip_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int LINE_WORDS = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    input  logic [3:0]  fdi,
    output logic [3:0]  fdo,
    output logic        fdoe,
    output logic        fsclk,
    output logic        fcen
);

    localparam int TAG_W = ADDR_W - 4;

    logic [2:0]               state_q;
    logic                     fcen_q;
    logic                     hready_q;
    logic [31:0]              rdata_q;
    logic                     valid_q;
    logic [TAG_W-1:0]         tag_q;
    logic [1:0]               widx_q;
    logic [4:0]               nib_q;
    logic [LINE_WORDS*32-1:0] line_q;

    logic       sh_start;
    shift_cfg_t sh_cfg;
    logic       sh_done;
    logic       sh_rx_vld;
    logic [3:0] sh_rx_dat;

    logic              accept;
    logic              hit;
    logic [ADDR_W-1:0] line_base;
    logic              unused_ok;

    assign accept    = HSEL & HREADY & HTRANS[1] & (state_q == ST_IDLE);
    assign hit       = valid_q & (tag_q == HADDR[ADDR_W-1:4]);
    assign line_base = {tag_q, 4'h0};
    assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[31:ADDR_W], HADDR[1:0]};

    assign HREADYOUT = hready_q;
    assign HRDATA    = rdata_q;
    assign HRESP     = 1'b0;
    assign fcen      = fcen_q;

    // Each phase is loaded on the edge that finishes the previous one, so flash clocks never pause
    always_comb begin
        sh_start = 1'b0;
        sh_cfg   = '0;
        case (state_q)
            ST_CS: begin
                sh_start = 1'b1;
                sh_cfg   = '{quad: 1'b0, oe: 1'b1, nclk: CLK_CMD, tx: {CMD_QIOR, 24'h0}};
            end
            ST_CMD: if (sh_done) begin
                sh_start = 1'b1;
                sh_cfg   = '{quad: 1'b1, oe: 1'b1, nclk: CLK_ADDR, tx: {24'(line_base), 8'h00}};
            end
            ST_ADDR: if (sh_done) begin
                sh_start = 1'b1;
                sh_cfg   = '{quad: 1'b1, oe: 1'b1, nclk: CLK_MODE, tx: {MODE_BITS, 24'h0}};
            end
            ST_MODE: if (sh_done) begin
                sh_start = 1'b1;
                sh_cfg   = '{quad: 1'b1, oe: 1'b0, nclk: CLK_DUMMY, tx: 32'h0};
            end
            ST_DUMMY: if (sh_done) begin
                sh_start = 1'b1;
                sh_cfg   = '{quad: 1'b1, oe: 1'b0, nclk: CLK_DATA, tx: 32'h0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            fcen_q   <= 1'b1;
            hready_q <= 1'b1;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            widx_q   <= '0;
            nib_q    <= '0;
            line_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept && !HWRITE) begin
                    if (hit) begin
                        rdata_q <= line_q[{HADDR[3:2], 5'b0} +: 32];
                    end else begin
                        // Line is invalid from here until the fill finishes
                        hready_q <= 1'b0;
                        fcen_q   <= 1'b0;
                        valid_q  <= 1'b0;
                        tag_q    <= HADDR[ADDR_W-1:4];
                        widx_q   <= HADDR[3:2];
                        nib_q    <= '0;
                        state_q  <= ST_CS;
                    end
                end
                ST_CS:    state_q <= ST_CMD;
                ST_CMD:   if (sh_done) state_q <= ST_ADDR;
                ST_ADDR:  if (sh_done) state_q <= ST_MODE;
                ST_MODE:  if (sh_done) state_q <= ST_DUMMY;
                ST_DUMMY: if (sh_done) state_q <= ST_DATA;
                ST_DATA: begin
                    if (sh_rx_vld) begin
                        line_q[nib_bit_pos(nib_q) +: 4] <= sh_rx_dat;
                        nib_q <= nib_q + 5'd1;
                    end
                    if (sh_done) begin
                        fcen_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_q  <= 1'b1;
                    hready_q <= 1'b1;
                    rdata_q  <= line_q[{widx_q, 5'b0} +: 32];
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    qspi_shifter u_shifter (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start_vld (sh_start),
        .cfg       (sh_cfg),
        .done      (sh_done),
        .rx_vld    (sh_rx_vld),
        .rx_dat    (sh_rx_dat),
        .fdi       (fdi),
        .fdo       (fdo),
        .fdoe      (fdoe),
        .fsclk     (fsclk)
    );

endmodule

// File: tb/tb_flash_xip_ctrl.sv
// tb_flash_xip_ctrl: directed bench with an SST26-style quad-read flash model on the pins.
// Latency: n/a.
// Backpressure: the AHB master waits on HREADYOUT with a bounded cycle budget.
module tb_flash_xip_ctrl;

    localparam int CLK_P = 10;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic [1:0]  HTRANS  = 2'b00;
    logic        HWRITE  = 1'b0;
    logic [2:0]  HSIZE   = 3'd2;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [3:0]  fdi = 4'h0;
    logic [3:0]  fdo;
    logic        fdoe;
    logic        fsclk;
    logic        fcen;

    assign HREADY = HREADYOUT;

    always #(CLK_P/2) HCLK = ~HCLK;

    flash_xip_ctrl dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .fdi(fdi), .fdo(fdo), .fdoe(fdoe),
        .fsclk(fsclk), .fcen(fcen)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- flash model: counts rising fsclk edges per chip-select ----------------
    logic [7:0]  mem [0:255];
    int          rcnt = 0, fcen_falls = 0, oe_err = 0, last_rcnt = 0, last_gap = 0;
    logic [7:0]  cmd_sh = '0, mode_sh = '0, last_cmd = '0, last_mode = '0;
    logic [23:0] adr_sh = '0, last_addr = '0;
    time         t_rise = 0;
    int          nib_i;
    logic [7:0]  nib_b;

    always @(negedge fcen) begin
        rcnt = 0;
        fcen_falls++;
        last_gap = int'(($time - t_rise) / CLK_P);
    end

    always @(posedge fcen) begin
        t_rise    = $time;
        last_rcnt = rcnt;
        last_cmd  = cmd_sh;
        last_addr = adr_sh;
        last_mode = mode_sh;
    end

    always @(posedge fsclk) begin
        if (fcen === 1'b0) begin
            rcnt++;
            if (rcnt <= 8) begin
                cmd_sh = {cmd_sh[6:0], fdo[0]};
                if (fdo[3:1] !== 3'b000) oe_err++;
            end else if (rcnt <= 14) begin
                adr_sh = {adr_sh[19:0], fdo};
            end else if (rcnt <= 16) begin
                mode_sh = {mode_sh[3:0], fdo};
            end
            if ((rcnt <= 16) != (fdoe === 1'b1)) oe_err++;
        end
    end

    // Data nibble n is driven after the falling edge that closes rising edge 20+n
    always @(negedge fsclk) begin
        if (fcen === 1'b0 && rcnt >= 20) begin
            nib_i = rcnt - 20;
            nib_b = mem[8'(adr_sh + 24'(nib_i / 2))];
            fdi   = nib_i[0] ? nib_b[3:0] : nib_b[7:4];
        end
    end

    // ---------------- AHB master ----------------
    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d, output int waits);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        waits = 0;
        while (HREADYOUT !== 1'b1 && waits < 300) begin
            @(posedge HCLK); #1;
            waits++;
        end
        chk("rd_ready", {31'b0, HREADYOUT}, 32'd1);
        d = HRDATA;
    endtask

    logic [31:0] d;
    int          w, f0, k;
    logic [31:0] hit_addr [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] hit_data [3] = '{32'h0010_0073, 32'h4433_2211, 32'h3CC3_5AA5};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]  = 8'h13; mem[1]  = 8'h00; mem[2]  = 8'h00; mem[3]  = 8'h00;
        mem[4]  = 8'h73; mem[5]  = 8'h00; mem[6]  = 8'h10; mem[7]  = 8'h00;
        mem[8]  = 8'h11; mem[9]  = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
        mem[12] = 8'hA5; mem[13] = 8'h5A; mem[14] = 8'hC3; mem[15] = 8'h3C;
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;

        // Reset
        HRESETn = 1'b0;
        #100;
        chk("rst_fcen",   {31'b0, fcen},      32'd1);
        chk("rst_fsclk",  {31'b0, fsclk},     32'd0);
        chk("rst_fdoe",   {31'b0, fdoe},      32'd0);
        chk("rst_fdo",    {28'b0, fdo},       32'd0);
        chk("rst_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("rst_hresp",  {31'b0, HRESP},     32'd0);
        chk("rst_hrdata", HRDATA,             32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Cold miss
        f0 = fcen_falls;
        ahb_read(32'h0, d, w);
        chk("cold_data",   d, 32'h0000_0013);
        chk("cold_lat_le110", (w <= 109) ? 32'd1 : 32'd0, 32'd1);
        chk("cold_cmd",    {24'b0, last_cmd},  32'hEB);
        chk("cold_addr",   {8'b0, last_addr},  32'h0);
        chk("cold_mode",   {24'b0, last_mode}, 32'h0);
        chk("cold_fclks",  last_rcnt,          32'd52);
        chk("cold_txns",   fcen_falls - f0,    32'd1);
        chk("cold_oe_err", oe_err,             32'd0);

        // Hits on the filled line
        f0 = fcen_falls;
        for (int i = 0; i < 3; i++) begin
            ahb_read(hit_addr[i], d, w);
            chk("hit_data",  d, hit_data[i]);
            chk("hit_waits", w, 32'd0);
        end
        chk("hit_no_txn", fcen_falls - f0, 32'd0);

        // Line change, back to back
        f0 = fcen_falls;
        ahb_read(32'h10, d, w);
        chk("lc1_data", d, 32'hDEAD_BEEF);
        chk("lc1_addr", {8'b0, last_addr}, 32'h10);
        ahb_read(32'h0, d, w);
        chk("lc2_data", d, 32'h0000_0013);
        chk("lc2_addr", {8'b0, last_addr}, 32'h0);
        chk("lc_gap_ge2", (last_gap >= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("lc_txns", fcen_falls - f0, 32'd2);

        // Write is dropped with no wait state
        f0 = fcen_falls;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        chk("wr_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("wr_hresp",  {31'b0, HRESP},     32'd0);
        repeat (5) @(posedge HCLK);
        #1;
        chk("wr_no_txn", fcen_falls - f0, 32'd0);
        ahb_read(32'h0, d, w);
        chk("wr_line_data",  d, 32'h0000_0013);
        chk("wr_line_waits", w, 32'd0);

        // Reset during the data phase of a fill
        f0 = fcen_falls;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        k = 0;
        while (rcnt < 30 && k < 300) begin
            @(posedge HCLK); #1;
            k++;
        end
        chk("mid_in_data", (rcnt >= 30 && fcen === 1'b0) ? 32'd1 : 32'd0, 32'd1);
        #3;
        HRESETn = 1'b0;
        #1;
        chk("mid_fcen",   {31'b0, fcen},      32'd1);
        chk("mid_hready", {31'b0, HREADYOUT}, 32'd1);
        #50;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(32'h10, d, w);
        chk("refetch_data",  d, 32'hDEAD_BEEF);
        chk("refetch_stall", (w > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("refetch_txns",  fcen_falls - f0, 32'd2);
        chk("refetch_fclks", last_rcnt, 32'd52);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
